// File: rtl/lp805x_sfr_pkg.sv
// Shared types and defaults for the SFR put/get responder.
// State encodings and default widths for the peripheral-side FSM.
package lp805x_sfr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } sfr_state_e;

    localparam int SFR_DW    = 8;
    localparam int SFR_DEPTH = 4;
    localparam int SFR_TMO   = 15;

endpackage

// File: rtl/lp805x_sfr_fifo.sv
// Small synchronous FIFO holding peripheral result bytes.
// Head is read combinationally; pop on an empty FIFO is ignored.
module lp805x_sfr_fifo
    import lp805x_sfr_pkg::*;
#(
    parameter int DW    = SFR_DW,
    parameter int DEPTH = SFR_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          push_drop
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_rd;
    logic w_wr;

    assign full      = (r_cnt == FULL_CNT);
    assign empty     = (r_cnt == '0);
    assign w_rd      = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_wr      = push && (!full || w_rd);
    assign push_drop = push && !w_wr;
    assign head      = r_mem[r_rp];
    assign count     = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            if (w_wr && !w_rd) r_cnt <= r_cnt + 1'b1;
            else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/lp805x_sfr_presp.sv
// Peripheral-side SFR responder: offers the FIFO head, holds it
// stable through the read, and pops it on the put commit.
module lp805x_sfr_presp
    import lp805x_sfr_pkg::*;
#(
    parameter int DW    = SFR_DW,
    parameter int DEPTH = SFR_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int TMO   = SFR_TMO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          periph_we,
    input  logic [DW-1:0] periph_di,
    output logic          periph_full,
    output logic [AW:0]   count,
    output logic          sfr_prrdy,
    input  logic          sfr_pget,
    output logic          sfr_pwrdy,
    input  logic          sfr_pput,
    output logic [DW-1:0] sfr_pdo,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_T   = TW'(TMO);
    localparam logic [TW-1:0] TMR_MAX = '1;

    sfr_state_e    r_state;
    sfr_state_e    w_state_nx;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nx;
    logic          r_prrdy;
    logic          w_prrdy_nx;
    logic          r_pwrdy;
    logic          w_pwrdy_nx;
    logic [DW-1:0] r_pdo;
    logic [DW-1:0] w_pdo_nx;
    logic          r_ovf;

    logic [DW-1:0] w_head;
    logic          w_empty;
    logic          w_drop;
    logic          w_pop;

    assign w_pop = (r_state == ST_HOLD) && sfr_pput;

    lp805x_sfr_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (periph_we),
        .pop       (w_pop),
        .din       (periph_di),
        .head      (w_head),
        .count     (count),
        .full      (periph_full),
        .empty     (w_empty),
        .push_drop (w_drop)
    );

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_prrdy_nx = 1'b0;
        w_pwrdy_nx = r_pwrdy;
        w_pdo_nx   = r_pdo;
        unique case (r_state)
            ST_IDLE: begin
                w_pwrdy_nx = 1'b0;
                if (!w_empty && !sfr_pget) begin
                    w_pdo_nx   = w_head;
                    w_prrdy_nx = 1'b1;
                    w_timer_nx = '0;
                    w_state_nx = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (sfr_pget) begin
                    w_pwrdy_nx = 1'b1;
                    w_timer_nx = '0;
                    w_state_nx = ST_HOLD;
                end else if (TMO != 0 && r_timer == TMO_T) begin
                    w_prrdy_nx = 1'b1;
                    w_timer_nx = '0;
                end else if (r_timer != TMR_MAX) begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            ST_HOLD: begin
                // get may drop a cycle before put; only put ends the read.
                w_pwrdy_nx = 1'b1;
                if (sfr_pput) begin
                    w_pwrdy_nx = 1'b0;
                    w_timer_nx = '0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_pwrdy_nx = 1'b0;
                w_timer_nx = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_prrdy <= 1'b0;
            r_pwrdy <= 1'b0;
            r_pdo   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_prrdy <= w_prrdy_nx;
            r_pwrdy <= w_pwrdy_nx;
            r_pdo   <= w_pdo_nx;
        end
    end

    // A dropped push outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
        else if (ovf_clr) r_ovf <= 1'b0;
    end

    assign sfr_prrdy = r_prrdy;
    assign sfr_pwrdy = r_pwrdy;
    assign sfr_pdo   = r_pdo;
    assign ovf       = r_ovf;

endmodule
